mr_wb_regfile: RTL and testbench

MR_WB_REGFILE -- requirements
Module: mr_wb_regfile

---
 rtl/mr_wb_regfile.sv | 96 +++++++++
 tb/tb_mr_wb_regfile.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mr_wb_regfile.sv
// Register file with per-register busy scoreboard for a single-issue pipeline.
// Issue is stalled on RAW/WAW hazards; operands are registered with writeback bypass.
module mr_wb_regfile #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned REGSEL_BITS = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_write_i,
  input  logic [XLEN-1:0]        wb_payload_i,
  input  logic [REGSEL_BITS-1:0] wb_dst_reg_i,
  input  logic                   iss_valid_i,
  input  logic [REGSEL_BITS-1:0] iss_rs1_i,
  input  logic [REGSEL_BITS-1:0] iss_rs2_i,
  input  logic [REGSEL_BITS-1:0] iss_rd_i,
  input  logic                   iss_rd_we_i,
  output logic                   iss_ready_o,
  output logic                   op_valid_o,
  output logic [XLEN-1:0]        rs1_data_o,
  output logic [XLEN-1:0]        rs2_data_o
);

  localparam int unsigned NumRegs = 2 ** REGSEL_BITS;

  logic [XLEN-1:0]    regs_q [NumRegs];
  logic [NumRegs-1:0] busy_q, busy_d;
  logic               op_valid_q;
  logic [XLEN-1:0]    rs1_q, rs2_q;

  logic            rs1_hit_wb, rs2_hit_wb, rd_hit_wb;
  logic            rs1_busy, rs2_busy, rd_busy;
  logic            iss_accept;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  // A writeback landing this cycle releases the register in time for the issue.
  always_comb begin
    rs1_hit_wb = wb_write_i && (wb_dst_reg_i == iss_rs1_i);
    rs2_hit_wb = wb_write_i && (wb_dst_reg_i == iss_rs2_i);
    rd_hit_wb  = wb_write_i && (wb_dst_reg_i == iss_rd_i);
    rs1_busy   = busy_q[iss_rs1_i] && !rs1_hit_wb;
    rs2_busy   = busy_q[iss_rs2_i] && !rs2_hit_wb;
    rd_busy    = busy_q[iss_rd_i] && !rd_hit_wb;
    iss_ready_o = !reset && !(rs1_busy || rs2_busy || (iss_rd_we_i && rd_busy));
    iss_accept  = iss_valid_i && iss_ready_o;
  end

  always_comb begin
    rs1_fwd = '0;
    rs2_fwd = '0;
    if (iss_rs1_i != '0) rs1_fwd = rs1_hit_wb ? wb_payload_i : regs_q[iss_rs1_i];
    if (iss_rs2_i != '0) rs2_fwd = rs2_hit_wb ? wb_payload_i : regs_q[iss_rs2_i];
  end

  // Set after clear so a new issue to the same rd keeps the register reserved.
  always_comb begin
    busy_d = busy_q;
    if (wb_write_i) busy_d[wb_dst_reg_i] = 1'b0;
    if (iss_accept && iss_rd_we_i && (iss_rd_i != '0)) busy_d[iss_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else if (wb_write_i && (wb_dst_reg_i != '0)) begin
      regs_q[wb_dst_reg_i] <= wb_payload_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_valid_q <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
    end else begin
      op_valid_q <= iss_accept;
      if (iss_accept) begin
        rs1_q <= rs1_fwd;
        rs2_q <= rs2_fwd;
      end
    end
  end

  assign op_valid_o = op_valid_q;
  assign rs1_data_o = rs1_q;
  assign rs2_data_o = rs2_q;

endmodule

// File: tb/tb_mr_wb_regfile.sv
// Directed self-checking bench for mr_wb_regfile: scoreboard stalls, bypass, x0, reset.
module tb_mr_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_write_i;
  logic [31:0] wb_payload_i;
  logic [4:0]  wb_dst_reg_i;
  logic        iss_valid_i;
  logic [4:0]  iss_rs1_i, iss_rs2_i, iss_rd_i;
  logic        iss_rd_we_i;
  logic        iss_ready_o;
  logic        op_valid_o;
  logic [31:0] rs1_data_o, rs2_data_o;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mr_wb_regfile #(.XLEN(32), .REGSEL_BITS(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_write_i   (wb_write_i),
    .wb_payload_i (wb_payload_i),
    .wb_dst_reg_i (wb_dst_reg_i),
    .iss_valid_i  (iss_valid_i),
    .iss_rs1_i    (iss_rs1_i),
    .iss_rs2_i    (iss_rs2_i),
    .iss_rd_i     (iss_rd_i),
    .iss_rd_we_i  (iss_rd_we_i),
    .iss_ready_o  (iss_ready_o),
    .op_valid_o   (op_valid_o),
    .rs1_data_o   (rs1_data_o),
    .rs2_data_o   (rs2_data_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_write_i   = 1'b0;
    wb_payload_i = '0;
    wb_dst_reg_i = '0;
    iss_valid_i  = 1'b0;
    iss_rs1_i    = '0;
    iss_rs2_i    = '0;
    iss_rd_i     = '0;
    iss_rd_we_i  = 1'b0;
  endtask

  task automatic set_wb(input logic [4:0] idx, input logic [31:0] val);
    wb_write_i = 1'b1; wb_dst_reg_i = idx; wb_payload_i = val;
  endtask

  task automatic set_iss(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic we);
    iss_valid_i = 1'b1; iss_rs1_i = rs1; iss_rs2_i = rs2; iss_rd_i = rd; iss_rd_we_i = we;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    set_iss(5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    vectors++;
    if (iss_ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", iss_ready_o);
    end
    tick(); tick();
    vectors++;
    if (op_valid_o !== 1'b0 || rs1_data_o !== 32'h0 || rs2_data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outs: got v=%b %h %h want 0 0 0", op_valid_o, rs1_data_o, rs2_data_o);
    end
    idle();
    reset = 1'b0;
    #1;
    vectors++;
    if (iss_ready_o !== 1'b1) begin
      errors++; $display("FAIL post_reset_ready: got %b want 1", iss_ready_o);
    end
  endtask

  task automatic test_basic();
    set_wb(5'd5, 32'hDEADBEEF);
    tick();
    idle();
    set_iss(5'd5, 5'd0, 5'd0, 1'b0);
    tick();
    idle();
    vectors++;
    if (op_valid_o !== 1'b1 || rs1_data_o !== 32'hDEADBEEF || rs2_data_o !== 32'h0) begin
      errors++;
      $display("FAIL basic_read: got v=%b %h %h want 1 deadbeef 0", op_valid_o, rs1_data_o,
               rs2_data_o);
    end
    tick();
    vectors++;
    if (op_valid_o !== 1'b0 || rs1_data_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_hold: got v=%b %h want 0 deadbeef", op_valid_o, rs1_data_o);
    end
  endtask

  task automatic test_hazard();
    set_iss(5'd0, 5'd0, 5'd7, 1'b1);
    tick();
    set_iss(5'd7, 5'd0, 5'd0, 1'b0);
    #1;
    vectors++;
    if (iss_ready_o !== 1'b0) begin
      errors++; $display("FAIL raw_stall: got %b want 0", iss_ready_o);
    end
    tick(); tick();
    vectors++;
    if (op_valid_o !== 1'b0 || iss_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL raw_stall_hold: got v=%b rdy=%b want 0 0", op_valid_o, iss_ready_o);
    end
    set_wb(5'd7, 32'h0000_1234);
    #1;
    vectors++;
    if (iss_ready_o !== 1'b1) begin
      errors++; $display("FAIL raw_release: got %b want 1", iss_ready_o);
    end
    tick();
    idle();
    vectors++;
    if (op_valid_o !== 1'b1 || rs1_data_o !== 32'h0000_1234) begin
      errors++;
      $display("FAIL raw_bypass: got v=%b %h want 1 00001234", op_valid_o, rs1_data_o);
    end
    iss_rs1_i = 5'd7;
    iss_rd_i = 5'd7;
    iss_rd_we_i = 1'b1;
    #1;
    vectors++;
    if (iss_ready_o !== 1'b1) begin
      errors++; $display("FAIL raw_cleared: got %b want 1", iss_ready_o);
    end
    idle();
  endtask

  task automatic test_same_edge();
    set_iss(5'd0, 5'd0, 5'd3, 1'b1);
    tick();
    idle();
    set_wb(5'd3, 32'h0000_AAAA);
    set_iss(5'd0, 5'd0, 5'd3, 1'b1);
    #1;
    vectors++;
    if (iss_ready_o !== 1'b1) begin
      errors++; $display("FAIL waw_release: got %b want 1", iss_ready_o);
    end
    tick();
    idle();
    iss_rs1_i = 5'd3;
    #1;
    vectors++;
    if (iss_ready_o !== 1'b0) begin
      errors++; $display("FAIL set_wins: got %b want 0", iss_ready_o);
    end
    set_wb(5'd3, 32'h0000_3333);
    tick();
    idle();
    set_iss(5'd3, 5'd5, 5'd0, 1'b0);
    #1;
    vectors++;
    if (iss_ready_o !== 1'b1) begin
      errors++; $display("FAIL x3_free: got %b want 1", iss_ready_o);
    end
    tick();
    idle();
    vectors++;
    if (op_valid_o !== 1'b1 || rs1_data_o !== 32'h0000_3333 || rs2_data_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL x3_read: got v=%b %h %h want 1 00003333 deadbeef", op_valid_o, rs1_data_o,
               rs2_data_o);
    end
  endtask

  task automatic test_x0();
    set_wb(5'd0, 32'hFFFF_FFFF);
    tick();
    idle();
    set_iss(5'd0, 5'd0, 5'd0, 1'b1);
    tick();
    vectors++;
    if (op_valid_o !== 1'b1 || rs1_data_o !== 32'h0 || iss_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL x0_read: got v=%b %h rdy=%b want 1 0 1", op_valid_o, rs1_data_o, iss_ready_o);
    end
    set_wb(5'd0, 32'hFFFF_FFFF);
    tick();
    idle();
    vectors++;
    if (rs1_data_o !== 32'h0 || rs2_data_o !== 32'h0) begin
      errors++; $display("FAIL x0_bypass: got %h %h want 0 0", rs1_data_o, rs2_data_o);
    end
  endtask

  task automatic test_reset_mid();
    set_iss(5'd0, 5'd0, 5'd9, 1'b1);
    tick();
    set_iss(5'd0, 5'd0, 5'd10, 1'b1);
    tick();
    reset = 1'b1;
    set_wb(5'd9, 32'h0000_0055);
    set_iss(5'd0, 5'd0, 5'd11, 1'b1);
    tick();
    reset = 1'b0;
    idle();
    vectors++;
    if (op_valid_o !== 1'b0 || rs1_data_o !== 32'h0 || rs2_data_o !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_outs: got v=%b %h %h want 0 0 0", op_valid_o, rs1_data_o,
               rs2_data_o);
    end
    set_iss(5'd9, 5'd5, 5'd10, 1'b1);
    #1;
    vectors++;
    if (iss_ready_o !== 1'b1) begin
      errors++; $display("FAIL mid_reset_busy: got %b want 1", iss_ready_o);
    end
    tick();
    idle();
    vectors++;
    if (op_valid_o !== 1'b1 || rs1_data_o !== 32'h0 || rs2_data_o !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_regs: got v=%b %h %h want 1 0 0", op_valid_o, rs1_data_o,
               rs2_data_o);
    end
    set_wb(5'd10, 32'h0);
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp1, exp2;
    for (int k = 1; k <= 4; k++) begin
      set_wb(5'(k), 32'h1111_1111 * k);
      tick();
    end
    idle();
    for (int k = 1; k <= 4; k++) begin
      set_iss(5'(k), 5'(5 - k), 5'(20 + k), 1'b1);
      tick();
      exp1 = 32'h1111_1111 * k;
      exp2 = 32'h1111_1111 * (5 - k);
      vectors++;
      if (op_valid_o !== 1'b1 || rs1_data_o !== exp1 || rs2_data_o !== exp2) begin
        errors++;
        $display("FAIL b2b_%0d: got v=%b %h %h want 1 %h %h", k, op_valid_o, rs1_data_o,
                 rs2_data_o, exp1, exp2);
      end
    end
    idle();
    tick();
    vectors++;
    if (op_valid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_end: got %b want 0", op_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hazard();
    test_same_edge();
    test_x0();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
